config_uart_tx: RTL and testbench
=================================

# config_uart_tx

Serial transmitter for the fabric configuration UART protocol. It takes a command byte and a stream of 32-bit configuration words and emits one complete comload frame on a single 8N1 line: sync header 0x00 0xAA 0xFF, command byte, then payload in binary or ASCII-hex encoding. It lets a host-side soft core or test harness drive fabric configuration over a loopback or board-to-board link. It also serves as the reference stimulus source for receiver verification.

## Interface

- ComRate, default 217: bit period is ComRate+1 CLK cycles, matching the receiver's reload-to-zero bit counter.
- IdleGap, default 16777: cycles Tx is held high after the last stop bit, so the receiver times out to idle before the next frame.
- CLK  in  1  single clock, all logic rising-edge.
- resetn  in  1  reset, asynchronous and active-low.
- Start  in  1  frame request; sampled only in Idle.
- Command  in  8  command byte, latched on accepted Start; bit 7 = 1 selects hex payload, 0 selects binary.
- WordData  in  32  payload word, sent MSB byte first.
- WordValid  in  1  WordData/WordLast valid.
- WordLast  in  1  marks the final word of the frame.
- WordReady  out  1  block can accept a word (registered).
- Tx  out  1  serial line; idle high.
- Busy  out  1  high from accepted Start until FrameDone.
- FrameDone  out  1  one-cycle pulse at frame end.

## Operation

- Byte format: start bit (0), 8 data bits LSB first, one stop bit (1). Each bit lasts ComRate+1 cycles, so one byte takes 10*(ComRate+1) cycles.
- Frame FSM states: Idle -> Sync0 (0x00) -> Sync1 (0xAA) -> Sync2 (0xFF) -> Cmd (latched Command) -> WaitWord -> SendData -> back to WaitWord, or to Gap if the latched last flag is set -> Idle.
- Idle: Busy=0 and Tx=1. When Start=1, latch Command, set Busy=1 and go to Sync0.
- WaitWord: WordReady=1. A handshake occurs when WordValid && WordReady. On handshake, latch WordData and WordLast, drop WordReady and go to SendData.
- SendData in binary mode (latched Command[7]=0): send 4 bytes, [31:24] down to [7:0].
- SendData in hex mode (Command[7]=1): send 8 characters, one per nibble, high nibble first. Nibble 0-9 maps to 0x30-0x39; nibble A-F maps to uppercase 0x41-0x46.
- Gap: hold Tx high for IdleGap cycles, pulse FrameDone for 1 cycle, clear Busy and return to Idle.
- Command value is not validated; it is sent verbatim.
- Boundary conditions:
  - Start while Busy=1 is ignored.
  - Changes to Command after acceptance have no effect.
  - WordValid already high on entry to WaitWord: handshake in the first WaitWord cycle.
  - Stall in WaitWord: Tx stays high indefinitely and no bytes are emitted. If the stall exceeds the receiver timeout, the receiver aborts the frame; this is the caller's responsibility.
  - WordLast on the first word gives a one-word frame. Zero-word frames are not supported.
- resetn low at any time: all state returns to Idle immediately (asynchronous). A byte in flight is truncated. On release the next frame restarts with a full header.

## Timing

- Reset values: Tx=1, Busy=0, WordReady=0, FrameDone=0.
- Start sampled at edge N: Busy=1 and Tx=0 (Sync0 start bit) from edge N+1.
- Bytes within a frame are back-to-back. The next start bit begins the cycle after the previous stop bit ends, so there is no inter-byte gap.
- Header duration: 40*(ComRate+1) cycles.
- Word duration: 40*(ComRate+1) cycles in binary mode, 80*(ComRate+1) in hex mode.
- WordReady rises the cycle after the Cmd stop bit ends, or after the last byte of the previous word. The first start bit of a word follows one cycle after the handshake.
- FrameDone pulses in the cycle after the IdleGap count expires. Busy falls in the same cycle.

## Structure

- Shared package config_uart_pkg holds:
  - frame FSM state encoding;
  - sync byte constants 0x00/0xAA/0xFF;
  - the hex-mode command bit index (7);
  - the nibble-to-ASCII function.
- Sub-module config_uart_tx_byte holds the bit-period counter and 10-bit shift register:
  - inputs: byte, load strobe;
  - outputs: Tx, a done pulse.
- The frame FSM, byte/nibble index counter and gap counter live in the top level.

## Test plan

All scenarios use ComRate=7 (8-cycle bits) and IdleGap=64.

- Reset check: assert resetn=0, then release -> Tx=1, Busy=0, WordReady=0, FrameDone=0 with no Start.
- Binary frame: Command=0x01, one word 0xDEADBEEF with WordLast=1 -> bytes 00 AA FF 01 DE AD BE EF, 80 cycles each, Tx high for 64 cycles, then a single FrameDone pulse. In loopback into the receiver this yields WriteData=0xDEADBEEF with exactly one WriteStrobe.
- Hex frame: Command=0x81, word 0x0123ABCD with WordLast=1 -> header 00 AA FF 81, then characters 30 31 32 33 41 42 43 44.
- Backpressure: two-word binary frame, WordValid withheld 500 cycles between words -> Tx constantly high during the stall, WordReady held at 1, exactly 8 payload bytes total.
- Start while Busy: pulse Start and change Command to 0x02 mid-payload -> no new header, the cmd byte already sent stays 0x01, and only one FrameDone pulse.
- Reset mid-byte: deassert resetn during the 2nd payload bit -> Tx=1 in the same cycle. A subsequent Start produces a full fresh header.

Source files
------------

// File: rtl/config_uart_pkg.sv
// rtl/config_uart_pkg.sv - shared types, constants and helpers for the config UART transmitter
package config_uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC0,
        ST_SYNC1,
        ST_SYNC2,
        ST_CMD,
        ST_WAIT_WORD,
        ST_SEND_DATA,
        ST_GAP
    } frame_state_t;

    localparam logic [7:0] SYNC0_BYTE  = 8'h00;
    localparam logic [7:0] SYNC1_BYTE  = 8'hAA;
    localparam logic [7:0] SYNC2_BYTE  = 8'hFF;
    localparam int         HEX_CMD_BIT = 7;

    // Uppercase ASCII hex digit for one nibble.
    function automatic logic [7:0] nib2ascii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return {4'h3, nib};
        end
        return 8'h37 + {4'h0, nib};
    endfunction

endpackage

// File: rtl/config_uart_tx_byte.sv
// rtl/config_uart_tx_byte.sv - one 8N1 byte serializer with bit-period counter
module config_uart_tx_byte #(
    parameter int COM_RATE = 217
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_load,
    input  logic [7:0] i_byte,
    output logic       o_tx,
    output logic       o_done
);

    localparam int CNT_W = (COM_RATE > 0) ? $clog2(COM_RATE + 1) : 1;

    logic             r_active;
    logic [9:0]       r_shift;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_bit;

    // A load in the stop-bit's final cycle wins, which keeps bytes back-to-back.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_active <= 1'b0;
            r_shift  <= '1;
            r_cnt    <= '0;
            r_bit    <= 4'd0;
        end else if (i_load) begin
            r_active <= 1'b1;
            r_shift  <= {1'b1, i_byte, 1'b0};
            r_cnt    <= CNT_W'(COM_RATE);
            r_bit    <= 4'd0;
        end else if (r_active) begin
            if (r_cnt == '0) begin
                if (r_bit == 4'd9) begin
                    r_active <= 1'b0;
                end else begin
                    r_shift <= {1'b1, r_shift[9:1]};
                    r_bit   <= r_bit + 4'd1;
                    r_cnt   <= CNT_W'(COM_RATE);
                end
            end else begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    assign o_tx   = r_active ? r_shift[0] : 1'b1;
    assign o_done = r_active && (r_cnt == '0) && (r_bit == 4'd9);

endmodule

// File: rtl/config_uart_tx.sv
// rtl/config_uart_tx.sv - comload frame transmitter: sync header, command byte, binary or hex payload
module config_uart_tx
    import config_uart_pkg::*;
#(
    parameter int COM_RATE = 217,
    parameter int IDLE_GAP = 16777
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic [7:0]  i_command,
    input  logic [31:0] i_word_data,
    input  logic        i_word_valid,
    input  logic        i_word_last,
    output logic        o_word_ready,
    output logic        o_tx,
    output logic        o_busy,
    output logic        o_frame_done
);

    localparam int GAP_W = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;

    frame_state_t     r_state;
    frame_state_t     w_next_state;
    logic [7:0]       r_cmd;
    logic [31:0]      r_word;
    logic             r_last;
    logic [3:0]       r_idx;
    logic [GAP_W-1:0] r_gap;
    logic             r_busy;
    logic             r_ready;
    logic             r_frame_done;

    logic             w_load;
    logic [7:0]       w_load_byte;
    logic             w_byte_done;
    logic             w_hex;
    logic             w_handshake;
    logic             w_word_end;
    logic             w_gap_zero;
    logic [3:0]       w_last_idx;
    logic [3:0]       w_nibble;
    logic [7:0]       w_bin_byte;

    assign w_hex       = r_cmd[HEX_CMD_BIT];
    assign w_last_idx  = w_hex ? 4'd8 : 4'd4;
    assign w_handshake = i_word_valid && r_ready;
    assign w_word_end  = (r_state == ST_SEND_DATA) && w_byte_done && (r_idx == w_last_idx);
    assign w_gap_zero  = (r_gap == '0);
    // r_idx counts up from the most significant byte/nibble.
    assign w_nibble    = r_word[{~r_idx[2:0], 2'b00} +: 4];
    assign w_bin_byte  = r_word[{~r_idx[1:0], 3'b000} +: 8];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:      if (i_start)     w_next_state = ST_SYNC0;
            ST_SYNC0:     if (w_byte_done) w_next_state = ST_SYNC1;
            ST_SYNC1:     if (w_byte_done) w_next_state = ST_SYNC2;
            ST_SYNC2:     if (w_byte_done) w_next_state = ST_CMD;
            ST_CMD:       if (w_byte_done) w_next_state = ST_WAIT_WORD;
            ST_WAIT_WORD: if (w_handshake) w_next_state = ST_SEND_DATA;
            ST_SEND_DATA: if (w_word_end)  w_next_state = r_last ? ST_GAP : ST_WAIT_WORD;
            ST_GAP:       if (w_gap_zero)  w_next_state = ST_IDLE;
            default:                       w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        w_load      = 1'b0;
        w_load_byte = SYNC0_BYTE;
        case (r_state)
            ST_IDLE: begin
                w_load = i_start;
            end
            ST_SYNC0: begin
                w_load      = w_byte_done;
                w_load_byte = SYNC1_BYTE;
            end
            ST_SYNC1: begin
                w_load      = w_byte_done;
                w_load_byte = SYNC2_BYTE;
            end
            ST_SYNC2: begin
                w_load      = w_byte_done;
                w_load_byte = r_cmd;
            end
            ST_SEND_DATA: begin
                w_load      = (r_idx == 4'd0) || (w_byte_done && (r_idx != w_last_idx));
                w_load_byte = w_hex ? nib2ascii(w_nibble) : w_bin_byte;
            end
            default: begin
                w_load = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cmd        <= 8'h00;
            r_word       <= 32'h0;
            r_last       <= 1'b0;
            r_idx        <= 4'd0;
            r_gap        <= '0;
            r_busy       <= 1'b0;
            r_ready      <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_cmd  <= i_command;
                        r_busy <= 1'b1;
                    end
                end
                ST_CMD: begin
                    if (w_byte_done) r_ready <= 1'b1;
                end
                ST_WAIT_WORD: begin
                    if (w_handshake) begin
                        r_word  <= i_word_data;
                        r_last  <= i_word_last;
                        r_ready <= 1'b0;
                        r_idx   <= 4'd0;
                    end
                end
                ST_SEND_DATA: begin
                    if (w_load) r_idx <= r_idx + 4'd1;
                    if (w_word_end) begin
                        if (r_last) r_gap   <= GAP_W'(IDLE_GAP - 1);
                        else        r_ready <= 1'b1;
                    end
                end
                ST_GAP: begin
                    if (w_gap_zero) begin
                        r_frame_done <= 1'b1;
                        r_busy       <= 1'b0;
                    end else begin
                        r_gap <= r_gap - 1'b1;
                    end
                end
                default: begin
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    config_uart_tx_byte #(
        .COM_RATE (COM_RATE)
    ) u_byte (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_load   (w_load),
        .i_byte   (w_load_byte),
        .o_tx     (o_tx),
        .o_done   (w_byte_done)
    );

    assign o_word_ready = r_ready;
    assign o_busy       = r_busy;
    assign o_frame_done = r_frame_done;

endmodule

// File: tb/tb_config_uart_tx.sv
// tb/tb_config_uart_tx.sv - randomized frame bench with a line decoder and byte-level reference model
module tb_config_uart_tx;

    localparam int BIT_CYC = 8;
    localparam int GAP_CYC = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_start;
    logic [7:0]  i_command;
    logic [31:0] i_word_data;
    logic        i_word_valid;
    logic        i_word_last;
    logic        o_word_ready;
    logic        o_tx;
    logic        o_busy;
    logic        o_frame_done;

    config_uart_tx #(
        .COM_RATE (BIT_CYC - 1),
        .IDLE_GAP (GAP_CYC)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start      (i_start),
        .i_command    (i_command),
        .i_word_data  (i_word_data),
        .i_word_valid (i_word_valid),
        .i_word_last  (i_word_last),
        .o_word_ready (o_word_ready),
        .o_tx         (o_tx),
        .o_busy       (o_busy),
        .o_frame_done (o_frame_done)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Line decoder: samples each bit mid-period, records byte and start-bit cycle.
    int         cyc = 0;
    int         m_phase = 0;
    int         m_cnt = 0;
    int         m_start = 0;
    logic [9:0] m_bits;
    logic [7:0] rx_q[$];
    int         rx_t[$];
    int         fd_count = 0;
    int         fd_cycle = 0;
    int         framing_bad = 0;

    always @(negedge clk) begin
        cyc++;
        if (o_frame_done === 1'b1) begin
            fd_count++;
            fd_cycle = cyc;
        end
        if (rst_n !== 1'b1) begin
            m_phase = 0;
        end else if (m_phase == 0) begin
            if (o_tx === 1'b0) begin
                m_phase = 1;
                m_cnt   = 0;
                m_start = cyc;
            end
        end else begin
            m_cnt++;
            if (m_cnt % BIT_CYC == BIT_CYC / 2) m_bits[m_cnt / BIT_CYC] = o_tx;
            if (m_cnt == 9 * BIT_CYC + BIT_CYC / 2) begin
                if (m_bits[0] !== 1'b0 || m_bits[9] !== 1'b1) framing_bad++;
                rx_q.push_back(m_bits[8:1]);
                rx_t.push_back(m_start);
                m_phase = 0;
            end
        end
    end

    logic [31:0] words_q[$];

    task automatic send_start(input logic [7:0] cmd);
        @(posedge clk);
        #1;
        i_command = cmd;
        i_start   = 1'b1;
        @(posedge clk);
        #1;
        i_start   = 1'b0;
        i_command = ~cmd;
        expect_eq("busy_on_start", o_busy, 1'b1);
        expect_eq("tx_start_bit", o_tx, 1'b0);
    endtask

    task automatic run_frame(input logic [7:0] cmd, input int stall, input bit midstart);
        logic [7:0]  exp_q[$];
        logic [31:0] w;
        int n, bpw, fd0, t, bad, d, nib, stall_bad;
        bit boundary;
        n   = words_q.size();
        bpw = cmd[7] ? 8 : 4;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hAA);
        exp_q.push_back(8'hFF);
        exp_q.push_back(cmd);
        for (int k = 0; k < n; k++) begin
            w = words_q[k];
            if (cmd[7]) begin
                for (int j = 0; j < 8; j++) begin
                    nib = int'((w >> (28 - 4 * j)) & 32'hF);
                    exp_q.push_back(nib < 10 ? 8'(48 + nib) : 8'(65 + nib - 10));
                end
            end else begin
                for (int j = 0; j < 4; j++) exp_q.push_back(8'((w >> (24 - 8 * j)) & 32'hFF));
            end
        end
        rx_q.delete();
        rx_t.delete();
        framing_bad = 0;
        stall_bad   = 0;
        fd0         = fd_count;

        send_start(cmd);
        for (int k = 0; k < n; k++) begin
            i_word_data = words_q[k];
            i_word_last = (k == n - 1);
            i_word_valid = !(stall > 0 && k > 0);
            t = 0;
            while (o_word_ready !== 1'b1 && t < 4000) begin
                @(negedge clk);
                t++;
            end
            expect_eq("ready_seen", o_word_ready, 1'b1);
            if (stall > 0 && k > 0) begin
                for (int s = 0; s < stall; s++) begin
                    @(negedge clk);
                    if (o_tx !== 1'b1 || o_word_ready !== 1'b1) stall_bad++;
                end
                i_word_valid = 1'b1;
            end
            @(posedge clk);
            #1;
            i_word_valid = 1'b0;
            if (midstart && k == 0) begin
                i_command = 8'h02;
                i_start   = 1'b1;
                @(posedge clk);
                #1;
                i_start   = 1'b0;
            end
        end
        if (stall > 0) expect_eq("stall_line_idle", stall_bad, 0);

        t = 0;
        while (fd_count == fd0 && t < 4000) begin
            @(negedge clk);
            t++;
        end
        expect_eq("frame_done_seen", fd_count, fd0 + 1);
        expect_eq("busy_at_done", o_busy, 1'b0);
        if (rx_t.size() > 0)
            expect_eq("gap_to_done", fd_cycle - rx_t[rx_t.size() - 1], 10 * BIT_CYC + GAP_CYC);
        repeat (midstart ? 400 : 20) @(negedge clk);
        expect_eq("frame_done_once", fd_count, fd0 + 1);
        expect_eq("framing", framing_bad, 0);
        expect_eq("byte_count", rx_q.size(), exp_q.size());
        if (rx_q.size() == exp_q.size()) begin
            for (int i = 0; i < exp_q.size(); i++) expect_eq($sformatf("byte%0d", i), rx_q[i], exp_q[i]);
            bad = 0;
            for (int i = 1; i < rx_t.size(); i++) begin
                d        = rx_t[i] - rx_t[i - 1];
                boundary = (i >= 4) && ((i - 4) % bpw == 0);
                if (!boundary && d != 10 * BIT_CYC) bad++;
                if (boundary && stall == 0 && d != 10 * BIT_CYC + 2) bad++;
                if (boundary && d < 10 * BIT_CYC + 2) bad++;
            end
            expect_eq("byte_spacing", bad, 0);
        end
    endtask

    initial begin
        int t;
        int nw;
        int st;
        rst_n        = 1'b0;
        i_start      = 1'b0;
        i_command    = 8'h00;
        i_word_data  = 32'h0;
        i_word_valid = 1'b0;
        i_word_last  = 1'b0;
        repeat (3) @(negedge clk);
        expect_eq("rst_tx", o_tx, 1'b1);
        expect_eq("rst_busy", o_busy, 1'b0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        expect_eq("idle_tx", o_tx, 1'b1);
        expect_eq("idle_busy", o_busy, 1'b0);
        expect_eq("idle_ready", o_word_ready, 1'b0);
        expect_eq("idle_done", o_frame_done, 1'b0);

        words_q = '{32'hDEADBEEF};
        run_frame(8'h01, 0, 1'b0);
        words_q = '{32'h0123ABCD};
        run_frame(8'h81, 0, 1'b0);
        words_q = '{32'h11223344, 32'h55667788};
        run_frame(8'h01, 500, 1'b0);
        words_q = '{32'hDEADBEEF};
        run_frame(8'h01, 0, 1'b1);

        send_start(8'h01);
        i_word_data  = 32'h0;
        i_word_last  = 1'b1;
        i_word_valid = 1'b1;
        t = 0;
        while (o_word_ready !== 1'b1 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        expect_eq("rst_ready_seen", o_word_ready, 1'b1);
        @(posedge clk);
        #1;
        i_word_valid = 1'b0;
        t = 0;
        while (o_tx !== 1'b0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        repeat (BIT_CYC + BIT_CYC / 2) @(negedge clk);
        expect_eq("tx_mid_payload", o_tx, 1'b0);
        rst_n = 1'b0;
        #1;
        expect_eq("rst_mid_tx", o_tx, 1'b1);
        expect_eq("rst_mid_busy", o_busy, 1'b0);
        expect_eq("rst_mid_ready", o_word_ready, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        words_q = '{32'hCAFEF00D};
        run_frame(8'h42, 0, 1'b0);

        for (int f = 0; f < 10; f++) begin
            nw = $urandom_range(1, 3);
            st = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 40) : 0;
            words_q.delete();
            for (int k = 0; k < nw; k++) words_q.push_back($urandom);
            run_frame(8'($urandom), st, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
